// File: rtl/nibble_cla_pkg.sv
// Shared definitions for the nibble-serial lookahead adder: nibble width,
// FSM state encoding and index-width helper.
package nibble_cla_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // A single-nibble adder still needs a 1-bit index register.
   function automatic int idx_width(input int nibbles);
      return (nibbles <= 1) ? 1 : $clog2(nibbles);
   endfunction

endpackage

// File: rtl/nibble_cla4.sv
// Combinational 4-bit carry-lookahead slice: P/G terms, C[4:1] and the sum nibble.
// Also exposes C[3] so the top can form signed overflow on the last nibble.
module nibble_cla4
   import nibble_cla_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a_n,
   input  logic [NIBBLE_W-1:0] b_n,
   input  logic                c0,
   output logic [NIBBLE_W-1:0] s,
   output logic                c4,
   output logic                c3
);

   logic [NIBBLE_W-1:0] p;
   logic [NIBBLE_W-1:0] g;
   logic                c1;
   logic                c2;

   assign p = a_n ^ b_n;
   assign g = a_n & b_n;

   assign c1 = g[0] | (p[0] & c0);
   assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
   assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c0);
   assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c0);

   assign s = p ^ {c3, c2, c1, c0};

endmodule

// File: rtl/nibble_serial_cla_adder.sv
// Multi-cycle adder: one nibble per clock through a single lookahead slice,
// with valid/ready handshakes on the operand and result sides.
module nibble_serial_cla_adder
   import nibble_cla_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int NIBBLES = WIDTH / NIBBLE_W
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             done_valid,
   input  logic             done_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int                IDX_W = idx_width(NIBBLES);
   localparam logic [IDX_W-1:0]  LAST  = IDX_W'(NIBBLES - 1);

   state_t              state;
   state_t              state_nxt;
   logic [WIDTH-1:0]    a_q;
   logic [WIDTH-1:0]    b_q;
   logic [IDX_W-1:0]    idx;
   logic                carry;
   logic                accept;
   logic [NIBBLE_W-1:0] a_n;
   logic [NIBBLE_W-1:0] b_n;
   logic [NIBBLE_W-1:0] s_n;
   logic                c4;
   logic                c3;

   assign a_n = a_q[int'(idx) * NIBBLE_W +: NIBBLE_W];
   assign b_n = b_q[int'(idx) * NIBBLE_W +: NIBBLE_W];

   nibble_cla4 u_cla4 (
      .a_n (a_n),
      .b_n (b_n),
      .c0  (carry),
      .s   (s_n),
      .c4  (c4),
      .c3  (c3)
   );

   // Handshake flags decode straight from state so reset drives them with no clock.
   assign start_ready = (state == IDLE);
   assign done_valid  = (state == DONE);
   assign accept      = start_ready && start_valid;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_valid)  state_nxt = RUN;
         RUN:     if (idx == LAST)  state_nxt = DONE;
         DONE:    if (done_ready)   state_nxt = IDLE;
         default:                   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         idx      <= '0;
         carry    <= 1'b0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            a_q   <= a;
            b_q   <= b;
            carry <= cin;
            sum   <= '0;
            idx   <= '0;
         end else if (state == RUN) begin
            sum[int'(idx) * NIBBLE_W +: NIBBLE_W] <= s_n;
            carry <= c4;
            if (idx == LAST) begin
               cout     <= c4;
               overflow <= c3 ^ c4;
            end else begin
               idx <= idx + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_nibble_serial_cla_adder.sv
// Self-checking bench: directed vector table, handshake/reset corner sequences,
// and random operands on 16- and 8-bit instances against an arithmetic model.
module tb_nibble_serial_cla_adder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        cin = 1'b0;

   logic        sv16 = 1'b0, dr16 = 1'b0, sr16, dv16, co16, ov16;
   logic [15:0] sum16;
   logic        sv8 = 1'b0, dr8 = 1'b0, sr8, dv8, co8, ov8;
   logic [7:0]  sum8;

   bit          sel8 = 1'b0;
   logic        cur_sr, cur_dv, cur_co, cur_ov;
   logic [15:0] cur_sum;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   nibble_serial_cla_adder #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .start_valid(sv16), .start_ready(sr16),
      .a(a), .b(b), .cin(cin), .done_valid(dv16), .done_ready(dr16),
      .sum(sum16), .cout(co16), .overflow(ov16)
   );

   nibble_serial_cla_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start_valid(sv8), .start_ready(sr8),
      .a(a[7:0]), .b(b[7:0]), .cin(cin), .done_valid(dv8), .done_ready(dr8),
      .sum(sum8), .cout(co8), .overflow(ov8)
   );

   always_comb begin
      cur_sr  = sel8 ? sr8 : sr16;
      cur_dv  = sel8 ? dv8 : dv16;
      cur_co  = sel8 ? co8 : co16;
      cur_ov  = sel8 ? ov8 : ov16;
      cur_sum = sel8 ? {8'h00, sum8} : sum16;
   end

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain integer addition on the selected width.
   task automatic ref_add(input int w, input logic [15:0] x, input logic [15:0] y,
                          input logic c, output logic [15:0] s, output logic co,
                          output logic ov);
      logic [16:0] mask;
      logic [16:0] full;
      mask = (17'd1 << w) - 17'd1;
      full = ({1'b0, x} & mask) + ({1'b0, y} & mask) + {16'd0, c};
      s    = full[15:0] & mask[15:0];
      co   = full[w];
      ov   = (x[w-1] == y[w-1]) && (s[w-1] != x[w-1]);
   endtask

   task automatic set_sv(input logic v);
      if (sel8) sv8 = v; else sv16 = v;
   endtask

   task automatic set_dr(input logic v);
      if (sel8) dr8 = v; else dr16 = v;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!cur_sr && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!cur_sr) check("start_ready_timeout", 32'd0, 32'd1);
   endtask

   // Accepts one operation, scrambles the operand buses while it runs and
   // returns the latency in edges from accept to done_valid.
   task automatic start_op(input logic [15:0] x, input logic [15:0] y, input logic c,
                           output int lat);
      wait_ready();
      a = x; b = y; cin = c;
      set_sv(1'b1);
      @(posedge clk); #1;
      set_sv(1'b0);
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      lat = 0;
      while (!cur_dv && lat < 50) begin
         @(posedge clk); #1;
         lat++;
         a = 16'($urandom); b = 16'($urandom);
      end
      if (!cur_dv) check("done_valid_timeout", 32'd0, 32'd1);
   endtask

   task automatic finish_op();
      set_dr(1'b1);
      @(posedge clk); #1;
      set_dr(1'b0);
   endtask

   task automatic run_and_check(input string tag, input int w, input logic [15:0] x,
                                input logic [15:0] y, input logic c);
      int lat;
      logic [15:0] es;
      logic eco, eov;
      ref_add(w, x, y, c, es, eco, eov);
      start_op(x, y, c, lat);
      check({tag, "_sum"}, {16'd0, cur_sum}, {16'd0, es});
      check({tag, "_cout"}, {31'd0, cur_co}, {31'd0, eco});
      check({tag, "_ovf"}, {31'd0, cur_ov}, {31'd0, eov});
      finish_op();
   endtask

   initial begin
      int lat;
      int q[$];
      logic [15:0] held;

      vecs[0] = '{a:16'h00FF, b:16'h0001, cin:1'b0, sum:16'h0100, cout:1'b0, ovf:1'b0};
      vecs[1] = '{a:16'h1234, b:16'h4321, cin:1'b1, sum:16'h5556, cout:1'b0, ovf:1'b0};
      vecs[2] = '{a:16'hFFFF, b:16'h0001, cin:1'b0, sum:16'h0000, cout:1'b1, ovf:1'b0};
      vecs[3] = '{a:16'h7FFF, b:16'h0001, cin:1'b0, sum:16'h8000, cout:1'b0, ovf:1'b1};
      vecs[4] = '{a:16'h8000, b:16'h8000, cin:1'b0, sum:16'h0000, cout:1'b1, ovf:1'b1};

      // Reset state
      #12;
      check("rst_start_ready", {31'd0, sr16}, 32'd1);
      check("rst_done_valid", {31'd0, dv16}, 32'd0);
      check("rst_sum", {16'd0, sum16}, 32'd0);
      check("rst_cout", {31'd0, co16}, 32'd0);
      check("rst_ovf", {31'd0, ov16}, 32'd0);
      check("rst_start_ready8", {31'd0, sr8}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed table
      for (int i = 0; i < 5; i++) begin
         start_op(vecs[i].a, vecs[i].b, vecs[i].cin, lat);
         check($sformatf("vec%0d_latency", i), lat, 32'd4);
         check($sformatf("vec%0d_sum", i), {16'd0, sum16}, {16'd0, vecs[i].sum});
         check($sformatf("vec%0d_cout", i), {31'd0, co16}, {31'd0, vecs[i].cout});
         check($sformatf("vec%0d_ovf", i), {31'd0, ov16}, {31'd0, vecs[i].ovf});
         finish_op();
      end

      // Backpressure in DONE with operand buses wiggling
      start_op(16'h7FFF, 16'h0001, 1'b0, lat);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         a = 16'($urandom); b = 16'($urandom);
         check("bp_done_valid", {31'd0, dv16}, 32'd1);
         check("bp_start_ready", {31'd0, sr16}, 32'd0);
         check("bp_sum", {16'd0, sum16}, 32'h8000);
         check("bp_cout", {31'd0, co16}, 32'd0);
         check("bp_ovf", {31'd0, ov16}, 32'd1);
      end
      dr16 = 1'b1;
      #1;
      check("bp_start_ready_at_dr", {31'd0, sr16}, 32'd0);
      @(posedge clk); #1;
      dr16 = 1'b0;
      check("bp_start_ready_after", {31'd0, sr16}, 32'd1);
      check("bp_done_valid_after", {31'd0, dv16}, 32'd0);
      @(posedge clk); #1;
      check("idle_sum_held", {16'd0, sum16}, 32'h8000);
      check("idle_ovf_held", {31'd0, ov16}, 32'd1);

      // Asynchronous reset during nibble 2
      a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
      sv16 = 1'b1;
      @(posedge clk); #1;
      sv16 = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check("mid_rst_done_valid", {31'd0, dv16}, 32'd0);
      check("mid_rst_start_ready", {31'd0, sr16}, 32'd1);
      check("mid_rst_sum", {16'd0, sum16}, 32'd0);
      check("mid_rst_cout", {31'd0, co16}, 32'd0);
      check("mid_rst_ovf", {31'd0, ov16}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      start_op(16'h0001, 16'h0001, 1'b0, lat);
      check("post_rst_sum", {16'd0, sum16}, 32'h0002);
      check("post_rst_latency", lat, 32'd4);
      finish_op();

      // Back-to-back spacing with both handshakes held high
      @(negedge clk);
      a = 16'h0003; b = 16'h0004; cin = 1'b0;
      sv16 = 1'b1; dr16 = 1'b1;
      for (int cyc = 0; cyc < 16; cyc++) begin
         @(negedge clk);
         if (sr16) q.push_back(cyc);
      end
      sv16 = 1'b0;
      check("b2b_accepts", (q.size() >= 2) ? 32'd1 : 32'd0, 32'd1);
      if (q.size() >= 2) check("b2b_spacing", q[1] - q[0], 32'd6);
      begin
         int n = 0;
         while ((!sr16 || dv16) && n < 50) begin
            @(posedge clk); #1;
            n++;
         end
      end
      dr16 = 1'b0;
      held = sum16;
      check("b2b_sum", {16'd0, held}, 32'h0007);
      @(posedge clk); #1;

      // Random, 16-bit
      sel8 = 1'b0;
      for (int i = 0; i < 1000; i++)
         run_and_check("rnd16", 16, 16'($urandom), 16'($urandom), 1'($urandom));

      // Random, 8-bit, including its latency
      sel8 = 1'b1;
      start_op(16'h00FF, 16'h0001, 1'b1, lat);
      check("w8_latency", lat, 32'd2);
      check("w8_sum", {16'd0, cur_sum}, 32'h0001);
      check("w8_cout", {31'd0, cur_co}, 32'd1);
      finish_op();
      for (int i = 0; i < 1000; i++)
         run_and_check("rnd8", 8, 16'($urandom), 16'($urandom), 1'($urandom));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
